// File: rtl/hcheck_sink.sv
// Terminating sink for the two-phase hlang message channel: checks redundancy, counts messages/errors.
// Latency: ack toggles DLY edges after the capture edge; all outputs registered.
// Backpressure: one message in flight; the sender waits for the ack level to match its req.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 8
`endif

module hcheck_sink #(
  parameter int ASZ     = `NS_ADDRESS_SIZE,
  parameter int DSZ     = `NS_DATA_SIZE,
  parameter int RSZ     = `NS_REDUN_SIZE,
  parameter int CSZ     = 16,
  parameter int DLY     = 0,
  parameter int CHK_RED = 1
) (
  input  logic           gch_clk,
  input  logic           gch_reset,
  output logic           gch_ready,
  input  logic [ASZ-1:0] rcv0_addr,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic [RSZ-1:0] rcv0_red,
  input  logic           rcv0_req_in,
  output logic           rcv0_ack_out,
  output logic [CSZ-1:0] o_msg_cnt,
  output logic [CSZ-1:0] o_err_cnt,
  output logic [DSZ-1:0] o_last_dat,
  output logic           o_err
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT} state_t;

  localparam int         SW       = ASZ + DSZ + RSZ;
  localparam logic [7:0] DLY_LOAD = (DLY > 0) ? 8'(DLY - 1) : 8'd0;

  state_t         state_q, state_d;
  logic [7:0]     dcnt_q, dcnt_d;
  logic           ready_q, ready_d;
  logic           ack_q, ack_d;
  logic [CSZ-1:0] msg_q, msg_d;
  logic [CSZ-1:0] errc_q, errc_d;
  logic [DSZ-1:0] last_q, last_d;
  logic           err_q, err_d;

  logic           pending;
  logic           red_bad;
  logic [SW-1:0]  red_sum;

  assign pending = (rcv0_req_in != ack_q);
  assign red_sum = SW'(rcv0_addr) + SW'(rcv0_dat);
  assign red_bad = (CHK_RED != 0) && (rcv0_red != red_sum[RSZ-1:0]);

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    ready_d = ready_q;
    ack_d   = ack_q;
    msg_d   = msg_q;
    errc_d  = errc_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      S_INIT: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (pending) begin
          last_d = rcv0_dat;
          if (msg_q != '1) msg_d = msg_q + CSZ'(1);
          if (red_bad) begin
            err_d = 1'b1;
            if (errc_q != '1) errc_d = errc_q + CSZ'(1);
          end
          if (DLY == 0) begin
            ack_d = ~ack_q;
          end else begin
            state_d = S_WAIT;
            dcnt_d  = DLY_LOAD;
          end
        end
      end
      S_WAIT: begin
        // req is not looked at here; the sender cannot move until the ack toggles
        if (dcnt_q == 8'd0) begin
          ack_d   = ~ack_q;
          state_d = S_IDLE;
        end else begin
          dcnt_d = dcnt_q - 8'd1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge gch_clk) begin
    if (gch_reset) begin
      state_q <= S_INIT;
      dcnt_q  <= 8'd0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      msg_q   <= '0;
      errc_q  <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      msg_q   <= msg_d;
      errc_q  <= errc_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign gch_ready    = ready_q;
  assign rcv0_ack_out = ack_q;
  assign o_msg_cnt    = msg_q;
  assign o_err_cnt    = errc_q;
  assign o_last_dat   = last_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_hcheck_sink.sv
// Directed bench for hcheck_sink across delay, checking, saturation and reset-abort configurations.
module tb_hcheck_sink;

  localparam int ASZ = 8;
  localparam int DSZ = 16;
  localparam int RSZ = 8;

  logic           gch_clk = 1'b0;
  logic           gch_reset = 1'b1;
  logic [ASZ-1:0] addr = '0;
  logic [DSZ-1:0] dat = '0;
  logic [RSZ-1:0] red = '0;
  logic           req_a = 1'b0, req_b = 1'b0, req_c = 1'b0, req_d = 1'b0;

  logic           rdy_a, rdy_b, rdy_c, rdy_d, rdy_e;
  logic           ack_a, ack_b, ack_c, ack_d, ack_e;
  logic [15:0]    msg_a, msg_b, msg_d, msg_e;
  logic [15:0]    errc_a, errc_b, errc_d, errc_e;
  logic [2:0]     msg_c, errc_c;
  logic [DSZ-1:0] last_a, last_b, last_c, last_d, last_e;
  logic           err_a, err_b, err_c, err_d, err_e;

  int total = 0;
  int bad = 0;

  always #5 gch_clk = ~gch_clk;

  hcheck_sink #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .CSZ(16), .DLY(2), .CHK_RED(1)) u_a (
    .gch_clk(gch_clk), .gch_reset(gch_reset), .gch_ready(rdy_a),
    .rcv0_addr(addr), .rcv0_dat(dat), .rcv0_red(red),
    .rcv0_req_in(req_a), .rcv0_ack_out(ack_a),
    .o_msg_cnt(msg_a), .o_err_cnt(errc_a), .o_last_dat(last_a), .o_err(err_a));

  hcheck_sink #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .CSZ(16), .DLY(2), .CHK_RED(0)) u_b (
    .gch_clk(gch_clk), .gch_reset(gch_reset), .gch_ready(rdy_b),
    .rcv0_addr(addr), .rcv0_dat(dat), .rcv0_red(red),
    .rcv0_req_in(req_b), .rcv0_ack_out(ack_b),
    .o_msg_cnt(msg_b), .o_err_cnt(errc_b), .o_last_dat(last_b), .o_err(err_b));

  hcheck_sink #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .CSZ(3), .DLY(0), .CHK_RED(1)) u_c (
    .gch_clk(gch_clk), .gch_reset(gch_reset), .gch_ready(rdy_c),
    .rcv0_addr(addr), .rcv0_dat(dat), .rcv0_red(red),
    .rcv0_req_in(req_c), .rcv0_ack_out(ack_c),
    .o_msg_cnt(msg_c), .o_err_cnt(errc_c), .o_last_dat(last_c), .o_err(err_c));

  hcheck_sink #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .CSZ(16), .DLY(5), .CHK_RED(1)) u_d (
    .gch_clk(gch_clk), .gch_reset(gch_reset), .gch_ready(rdy_d),
    .rcv0_addr(addr), .rcv0_dat(dat), .rcv0_red(red),
    .rcv0_req_in(req_d), .rcv0_ack_out(ack_d),
    .o_msg_cnt(msg_d), .o_err_cnt(errc_d), .o_last_dat(last_d), .o_err(err_d));

  // null source: request level never moves
  hcheck_sink #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .CSZ(16), .DLY(0), .CHK_RED(1)) u_e (
    .gch_clk(gch_clk), .gch_reset(gch_reset), .gch_ready(rdy_e),
    .rcv0_addr('0), .rcv0_dat('0), .rcv0_red('0),
    .rcv0_req_in(1'b0), .rcv0_ack_out(ack_e),
    .o_msg_cnt(msg_e), .o_err_cnt(errc_e), .o_last_dat(last_e), .o_err(err_e));

  task automatic tick();
    @(posedge gch_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic ack_seen;
    logic [15:0] exp_msg;

    // reset and release
    tick(); tick(); tick();
    check("rst_ready", rdy_a, 0);
    check("rst_ack", ack_a, 0);
    check("rst_msg", msg_a, 0);
    check("rst_err", err_a, 0);
    gch_reset = 1'b0;
    #2;
    check("ready_before_edge", rdy_a, 0);
    tick();
    check("ready_after_release", rdy_a, 1);
    check("ready_after_release_e", rdy_e, 1);
    check("idle_errc", errc_a, 0);
    check("idle_last", last_a, 0);

    // DLY=2, good redundancy 3+5=8
    addr = 8'd3; dat = 16'd5; red = 8'd8; req_a = 1'b1;
    tick();
    check("good_msg", msg_a, 1);
    check("good_last", last_a, 5);
    check("good_ack_e0", ack_a, 0);
    check("good_err", err_a, 0);
    tick();
    check("good_ack_e1", ack_a, 0);
    tick();
    check("good_ack_e2", ack_a, 1);
    tick();
    check("good_ack_hold", ack_a, 1);

    // bad redundancy with checking on
    red = 8'd7; req_a = 1'b0;
    tick();
    check("bad_errc", errc_a, 1);
    check("bad_err", err_a, 1);
    check("bad_msg", msg_a, 2);
    tick(); tick();
    check("bad_ack_toggle", ack_a, 0);

    // same stimulus with checking off
    req_b = 1'b1;
    tick();
    check("nochk_err", err_b, 0);
    check("nochk_errc", errc_b, 0);
    check("nochk_msg", msg_b, 1);
    tick(); tick();
    check("nochk_ack", ack_b, 1);

    // DLY=0, CSZ=3, registered sender, 10 messages
    addr = 8'd0;
    for (int i = 1; i <= 10; i++) begin
      dat = 16'(i); red = 8'(i); req_c = ~req_c;
      tick();
      check("b2b_ack_capture", ack_c, req_c);
      exp_msg = (i < 7) ? 16'(i) : 16'd7;
      check("b2b_msg", msg_c, exp_msg);
      tick();
      check("b2b_ack_idle", ack_c, req_c);
    end
    check("b2b_sat", msg_c, 7);
    check("b2b_last", last_c, 10);
    check("b2b_final_ack", ack_c, 0);
    check("b2b_noerr", err_c, 0);

    // DLY=5, reset two cycles after capture
    addr = 8'd3; dat = 16'd5; red = 8'd8; req_d = 1'b1;
    tick();
    check("abort_msg", msg_d, 1);
    tick(); tick();
    gch_reset = 1'b1; req_d = 1'b0;
    tick();
    check("abort_ack", ack_d, 0);
    check("abort_msg_clr", msg_d, 0);
    check("abort_ready", rdy_d, 0);
    gch_reset = 1'b0;
    tick();
    check("abort_ready_back", rdy_d, 1);
    ack_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack_d !== 1'b0) ack_seen = 1'b1;
    end
    check("abort_no_ack", ack_seen, 0);
    check("abort_msg_quiet", msg_d, 0);

    // null source for 100 cycles
    ack_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ack_e !== 1'b0) ack_seen = 1'b1;
    end
    check("null_ack_const", ack_seen, 0);
    check("null_ready", rdy_e, 1);
    check("null_msg", msg_e, 0);
    check("null_err", err_e, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
